mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the pipelined MIPS core.
- Receives the same forwarded rs/rt operands as the ALU.
- Holds the architectural HI/LO registers.
- Its read-out result feeds the E-stage result select beside the ALU output, then goes into the E/M pipeline register.
- Multi-cycle multiply and divide are modelled with a countdown counter and a busy flag; the hazard unit uses the busy flag to stall.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (and MADD/MADDU when enabled); must be ≥1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; must be ≥1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  32  operand rs (forwarded).
- B  input  32  operand rt (forwarded).
- MDUOp  input  4  operation select:
  - 0000 NONE, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU
  - 0101 MFHI, 0110 MFLO, 0111 MTHI, 1000 MTLO
  - 1001 MADD, 1010 MADDU (only with the optional feature)
- start  input  1  qualifies MDUOp for this cycle; low when E stage holds a bubble.
- busy  output  1  multi-cycle operation in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- out  output  32  read-out result for MFHI/MFLO.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset: HI=0, LO=0, busy=0, counter=0, pending regs=0. An assertion mid-operation aborts the operation; HI/LO read 0 afterwards.
- out (combinational):
  - HI when MDUOp=MFHI, LO when MDUOp=MFLO, else 0.
  - Independent of start and busy; the hazard unit stalls MFHI/MFLO while busy.
- Accepting a multi-cycle op: only when start=1, busy=0 and MDUOp ∈ {MULT, MULTU, DIV, DIVU}. At that rising edge:
  - The 64-bit result is computed from A/B and latched into pending_hi/pending_lo.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy goes to 1.
- MULT: signed 32×32→64. pending_hi = product[63:32], pending_lo = product[31:0]. MULTU is the same, unsigned.
- DIV: signed. pending_lo = quotient truncated toward zero; pending_hi = remainder with the sign of the dividend. DIVU is the same, unsigned.
- Divide by zero (B=0): the op still goes busy for DIV_CYCLES, but HI/LO remain unchanged on completion.
- While busy:
  - counter decrements each edge.
  - At the edge where counter==1, HI/LO take pending values, counter goes to 0 and busy goes to 0, all at that same edge.
  - busy is therefore high for exactly N cycles after the accepting edge, and the new HI/LO are visible in the first cycle busy=0.
- start with any op while busy=1: ignored completely, including MTHI/MTLO. This condition is illegal under correct stalling; HI/LO and counter are unaffected.
- MTHI/MTLO with start=1, busy=0: HI (or LO) <= A at the edge. Takes one cycle; busy stays 0.
- MFHI/MFLO/NONE with start=1: no state change.
- start=0: no state change except the busy countdown.
- Undefined MDUOp codes: treated as NONE.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} += signed A×B.
  - MADDU: {HI,LO} += unsigned A×B, 64-bit wrap-around.
  - Both are accepted under the same rules as MULT and use MULT_CYCLES.
  - The sum uses the current HI/LO at the accepting edge.
- Undefined: codes 1001/1010 behave as NONE; no accumulator adder is synthesized.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, release -> HI=0, LO=0, busy=0, out=0. Then issue MFLO -> out=0.
- MULT vs MULTU, each followed by MFHI/MFLO after busy falls:
  - MULT A=0xFFFFFFFF, B=2 -> busy for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide:
  - DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 -> LO=3, HI=1.
- Divide by zero and start-while-busy:
  - MTHI A=0x1234 gives HI=0x1234 next cycle with busy=0.
  - DIV with B=0 -> 10 busy cycles, HI stays 0x1234.
  - During that busy window, pulse start with MTLO A=5 -> LO unchanged.
- Reset mid-op: start DIVU A=100, B=3; assert reset_n=0 at busy cycle 4 -> busy=0, HI=LO=0 immediately (asynchronous). After release, no late write occurs.
- MDU_MADD_EN defined:
  - HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0.
  - Same sequence with the macro undefined -> HI/LO unchanged, busy never asserts.

Source files
------------

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: holds HI/LO and models multi-cycle MULT/DIV latency with a countdown.
// Optional MADD/MADDU accumulate support is compiled in when MDU_MADD_EN is defined.
module mdu_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDUOp,
   input  logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] out
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'b0000,
      OP_MULT  = 4'b0001,
      OP_MULTU = 4'b0010,
      OP_DIV   = 4'b0011,
      OP_DIVU  = 4'b0100,
      OP_MFHI  = 4'b0101,
      OP_MFLO  = 4'b0110,
      OP_MTHI  = 4'b0111,
      OP_MTLO  = 4'b1000,
      OP_MADD  = 4'b1001,
      OP_MADDU = 4'b1010
   } mdu_op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t             r_state,   w_state_nxt;
   logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
   logic [31:0]        r_hi,      w_hi_nxt;
   logic [31:0]        r_lo,      w_lo_nxt;
   logic [31:0]        r_pend_hi, w_pend_hi_nxt;
   logic [31:0]        r_pend_lo, w_pend_lo_nxt;
   logic               r_nowrite, w_nowrite_nxt;

   logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
   logic [63:0] w_prod_s, w_prod_u;
   logic [31:0] w_divisor;
   logic [31:0] w_quot_s, w_rem_s, w_quot_u, w_rem_u;
   logic        w_b_zero;
   mdu_op_t     w_op;

   assign w_op     = mdu_op_t'(MDUOp);
   assign w_a_sx   = {{32{A[31]}}, A};
   assign w_b_sx   = {{32{B[31]}}, B};
   assign w_a_zx   = {32'h0, A};
   assign w_b_zx   = {32'h0, B};
   // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = w_a_zx * w_b_zx;

   assign w_b_zero  = (B == 32'h0);
   assign w_divisor = w_b_zero ? 32'h1 : B;
   assign w_quot_s  = $signed(A) / $signed(w_divisor);
   assign w_rem_s   = $signed(A) % $signed(w_divisor);
   assign w_quot_u  = A / w_divisor;
   assign w_rem_u   = A % w_divisor;

`ifdef MDU_MADD_EN
   logic [63:0] w_acc_s, w_acc_u;
   assign w_acc_s = {r_hi, r_lo} + w_prod_s;
   assign w_acc_u = {r_hi, r_lo} + w_prod_u;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_pend_hi_nxt = r_pend_hi;
      w_pend_lo_nxt = r_pend_lo;
      w_nowrite_nxt = r_nowrite;

      if (r_state == S_BUSY) begin
         // Any start while busy is dropped; only the countdown advances.
         if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            if (!r_nowrite) begin
               w_hi_nxt = r_pend_hi;
               w_lo_nxt = r_pend_lo;
            end
         end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
         end
      end else if (start) begin
         unique case (w_op)
            OP_MULT: begin
               {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_s;
               w_nowrite_nxt = 1'b0;
               w_cnt_nxt     = CNT_W'(MULT_CYCLES);
               w_state_nxt   = S_BUSY;
            end
            OP_MULTU: begin
               {w_pend_hi_nxt, w_pend_lo_nxt} = w_prod_u;
               w_nowrite_nxt = 1'b0;
               w_cnt_nxt     = CNT_W'(MULT_CYCLES);
               w_state_nxt   = S_BUSY;
            end
            OP_DIV: begin
               w_pend_hi_nxt = w_rem_s;
               w_pend_lo_nxt = w_quot_s;
               w_nowrite_nxt = w_b_zero;
               w_cnt_nxt     = CNT_W'(DIV_CYCLES);
               w_state_nxt   = S_BUSY;
            end
            OP_DIVU: begin
               w_pend_hi_nxt = w_rem_u;
               w_pend_lo_nxt = w_quot_u;
               w_nowrite_nxt = w_b_zero;
               w_cnt_nxt     = CNT_W'(DIV_CYCLES);
               w_state_nxt   = S_BUSY;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
               {w_pend_hi_nxt, w_pend_lo_nxt} = w_acc_s;
               w_nowrite_nxt = 1'b0;
               w_cnt_nxt     = CNT_W'(MULT_CYCLES);
               w_state_nxt   = S_BUSY;
            end
            OP_MADDU: begin
               {w_pend_hi_nxt, w_pend_lo_nxt} = w_acc_u;
               w_nowrite_nxt = 1'b0;
               w_cnt_nxt     = CNT_W'(MULT_CYCLES);
               w_state_nxt   = S_BUSY;
            end
`endif
            OP_MTHI: w_hi_nxt = A;
            OP_MTLO: w_lo_nxt = A;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_nowrite <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_pend_hi <= w_pend_hi_nxt;
         r_pend_lo <= w_pend_lo_nxt;
         r_nowrite <= w_nowrite_nxt;
      end
   end

   assign busy = (r_state == S_BUSY);
   assign HI   = r_hi;
   assign LO   = r_lo;

   always_comb begin
      out = '0;
      if (w_op == OP_MFHI)      out = r_hi;
      else if (w_op == OP_MFLO) out = r_lo;
   end

endmodule
